stage_fetch: RTL and testbench

Instruction-fetch stage of the 5-stage RV32I core; sits directly upstream of the decode stage and drives its `instrF`, `pcF`, `pcPlus4F`, `bPredictedTakenF` inputs. It owns the PC register and a direct-mapped branch predictor (BTB plus 2-bit saturating counters). It is redirected by execute on mispredicts and trained by resolved branches and jumps.

---
 rtl/stage_fetch_pkg.sv | 23 ++
 rtl/stage_fetch_if.sv | 32 +++
 rtl/stage_fetch_branch_predictor.sv | 72 +++++++
 rtl/stage_fetch.sv | 59 +++++
 tb/tb_stage_fetch.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/stage_fetch_pkg.sv
// Shared definitions for the fetch stage and its branch predictor.
package stage_fetch_pkg;

    // Counter value after reset: weakly not-taken.
    localparam logic [1:0] BTB_CTR_RESET = 2'b01;
    // Counter value for a freshly allocated entry: weakly taken.
    localparam logic [1:0] BTB_CTR_ALLOC = 2'b10;
    localparam logic [1:0] BTB_CTR_MAX   = 2'b11;
    localparam logic [1:0] BTB_CTR_MIN   = 2'b00;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic logic [1:0] ctrNext(input logic [1:0] ctr, input logic taken);
        logic [1:0] result;
        result = ctr;
        if (taken && ctr != BTB_CTR_MAX) begin
            result = ctr + 2'b01;
        end else if (!taken && ctr != BTB_CTR_MIN) begin
            result = ctr - 2'b01;
        end
        return result;
    endfunction

endpackage

// File: rtl/stage_fetch_if.sv
// Bundle of the fetch stage's control, training, imem and decode-facing signals.
interface stage_fetch_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        updateEn;
    logic [31:0] updatePc;
    logic        updateTaken;
    logic [31:0] updateTarget;
    logic [31:0] imemAddr;
    logic [31:0] imemData;
    logic [31:0] instrF;
    logic [31:0] pcF;
    logic [31:0] pcPlus4F;
    logic        bPredictedTakenF;

    // The fetch stage itself.
    modport master (
        input  stall, redirect, redirectPc,
        input  updateEn, updatePc, updateTaken, updateTarget,
        input  imemData,
        output imemAddr, instrF, pcF, pcPlus4F, bPredictedTakenF
    );

    // Surrounding core: hazard unit, execute, imem and decode.
    modport slave (
        output stall, redirect, redirectPc,
        output updateEn, updatePc, updateTaken, updateTarget,
        output imemData,
        input  imemAddr, instrF, pcF, pcPlus4F, bPredictedTakenF
    );
endinterface

// File: rtl/stage_fetch_branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters; combinational lookup,
// synchronous training. A lookup and an update in the same cycle do not bypass.
module branch_predictor
    import stage_fetch_pkg::*;
#(
    parameter int BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lookupPc,
    output logic        lookupTaken,
    output logic [31:0] lookupTarget,
    input  logic        updateEn,
    input  logic [31:0] updatePc,
    input  logic        updateTaken,
    input  logic [31:0] updateTarget
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic [1:0]       ctr;
    } btbEntry_t;

    btbEntry_t btb [BTB_ENTRIES];

    logic [IDX_W-1:0] lookupIdx;
    logic [TAG_W-1:0] lookupTag;
    logic [IDX_W-1:0] updIdx;
    logic [TAG_W-1:0] updTag;
    logic             updHit;
    btbEntry_t        lookupEntry;
    logic             unusedPcBits;

    assign lookupIdx    = lookupPc[IDX_W+1:2];
    assign lookupTag    = lookupPc[31:IDX_W+2];
    assign updIdx       = updatePc[IDX_W+1:2];
    assign updTag       = updatePc[31:IDX_W+2];
    assign unusedPcBits = ^{lookupPc[1:0], updatePc[1:0]};

    // Lookup: taken only on a tag hit whose counter leans taken.
    always_comb begin
        lookupEntry  = btb[lookupIdx];
        lookupTaken  = lookupEntry.valid && (lookupEntry.tag == lookupTag) && lookupEntry.ctr[1];
        lookupTarget = lookupEntry.target;
        updHit       = btb[updIdx].valid && (btb[updIdx].tag == updTag);
    end

    // Reset clears every entry; otherwise train hits and allocate taken misses.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb[i].valid <= 1'b0;
                btb[i].ctr   <= BTB_CTR_RESET;
            end
        end else if (updateEn) begin
            if (updHit) begin
                btb[updIdx].ctr <= ctrNext(btb[updIdx].ctr, updateTaken);
                if (updateTaken) begin
                    btb[updIdx].target <= updateTarget;
                end
            end else if (updateTaken) begin
                btb[updIdx] <= '{valid: 1'b1, tag: updTag, target: updateTarget, ctr: BTB_CTR_ALLOC};
            end
        end
    end

endmodule

// File: rtl/stage_fetch.sv
// Instruction-fetch stage: PC register, next-PC selection and branch prediction.
module stage_fetch
    import stage_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic          clk,
    input  logic          rst,
    stage_fetch_if.master bus
);

    logic [31:0] pcReg;
    logic [31:0] nextPc;
    logic [31:0] pcPlus4;
    logic        predTaken;
    logic [31:0] predTarget;

    branch_predictor #(.BTB_ENTRIES(BTB_ENTRIES)) predictor (
        .clk          (clk),
        .rst          (rst),
        .lookupPc     (pcReg),
        .lookupTaken  (predTaken),
        .lookupTarget (predTarget),
        .updateEn     (bus.updateEn),
        .updatePc     (bus.updatePc),
        .updateTaken  (bus.updateTaken),
        .updateTarget (bus.updateTarget)
    );

    assign pcPlus4              = pcReg + 32'd4;
    assign bus.imemAddr         = pcReg;
    assign bus.pcF              = pcReg;
    assign bus.pcPlus4F         = pcPlus4;
    assign bus.instrF           = bus.imemData;
    assign bus.bPredictedTakenF = predTaken;

    // Next PC: a redirect overrides a stall, a stall overrides prediction.
    always_comb begin
        nextPc = pcPlus4;
        if (bus.redirect) begin
            nextPc = bus.redirectPc;
        end else if (bus.stall) begin
            nextPc = pcReg;
        end else if (predTaken) begin
            nextPc = predTarget;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcReg <= RESET_PC;
        end else begin
            pcReg <= nextPc;
        end
    end

endmodule

// File: tb/tb_stage_fetch.sv
// Self-checking bench for stage_fetch: directed scenarios plus random traffic
// against a word-address-level reference model, checked through a scoreboard.
module tb_stage_fetch;

    localparam int          N        = 16;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pcPlus4;
        logic [31:0] instr;
        logic        taken;
    } expect_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    stage_fetch_if bus();

    stage_fetch #(.RESET_PC(RESET_PC), .BTB_ENTRIES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    expect_t sbQueue[$];
    expect_t monExp;
    int      checks = 0;
    int      errors = 0;

    // Reference model: an entry "owns" a word address; counters are plain ints.
    logic [31:0] mPc;
    bit          mKnown = 1'b0;
    bit          mValid  [N];
    logic [31:0] mOwner  [N];
    logic [31:0] mTarget [N];
    int          mCtr    [N];

    function automatic int idxOf(input logic [31:0] pc);
        return int'((pc >> 2) & 32'(N - 1));
    endfunction

    function automatic bit modelHit(input logic [31:0] pc);
        int i;
        i = idxOf(pc);
        return mValid[i] && (mOwner[i][31:2] == pc[31:2]);
    endfunction

    function automatic bit modelPredict(input logic [31:0] pc);
        return modelHit(pc) && (mCtr[idxOf(pc)] >= 2);
    endfunction

    function automatic logic [31:0] randPc();
        logic [31:0] p;
        p = $urandom_range(0, 63) << 2;
        if ($urandom_range(0, 3) == 0) p = p | 32'h400;
        if ($urandom_range(0, 15) == 0) p = $urandom;
        return p;
    endfunction

    task automatic compareField(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input expect_t e);
        compareField("pcF", bus.pcF, e.pc);
        compareField("imemAddr", bus.imemAddr, e.pc);
        compareField("pcPlus4F", bus.pcPlus4F, e.pcPlus4);
        compareField("instrF", bus.instrF, e.instr);
        compareField("bPredictedTakenF", {31'b0, bus.bPredictedTakenF}, {31'b0, e.taken});
    endtask

    // Drive one cycle, queue what the outputs must show, then advance the model.
    task automatic applyStimulus(input bit r, input bit st, input bit rd, input logic [31:0] rpc,
                                 input bit ue, input logic [31:0] upc, input bit ut,
                                 input logic [31:0] utg);
        logic [31:0] word;
        bit          pred;
        int          ui;
        expect_t     e;
        word             = $urandom;
        rst              = r;
        bus.stall        = st;
        bus.redirect     = rd;
        bus.redirectPc   = rpc;
        bus.updateEn     = ue;
        bus.updatePc     = upc;
        bus.updateTaken  = ut;
        bus.updateTarget = utg;
        bus.imemData     = word;
        if (mKnown) begin
            pred      = modelPredict(mPc);
            e.pc      = mPc;
            e.pcPlus4 = mPc + 32'd4;
            e.instr   = word;
            e.taken   = pred;
            sbQueue.push_back(e);
        end
        if (r) begin
            mKnown = 1'b1;
            mPc    = RESET_PC;
            for (int i = 0; i < N; i++) begin
                mValid[i] = 1'b0;
                mCtr[i]   = 1;
            end
        end else if (mKnown) begin
            if (rd) mPc = rpc;
            else if (st) mPc = mPc;
            else if (pred) mPc = mTarget[idxOf(mPc)];
            else mPc = mPc + 32'd4;
            if (ue) begin
                ui = idxOf(upc);
                if (modelHit(upc)) begin
                    if (ut) begin
                        mCtr[ui]    = (mCtr[ui] < 3) ? mCtr[ui] + 1 : 3;
                        mTarget[ui] = utg;
                    end else begin
                        mCtr[ui] = (mCtr[ui] > 0) ? mCtr[ui] - 1 : 0;
                    end
                end else if (ut) begin
                    mValid[ui]  = 1'b1;
                    mOwner[ui]  = upc;
                    mTarget[ui] = utg;
                    mCtr[ui]    = 2;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic jumpTo(input logic [31:0] pc);
        applyStimulus(1'b0, 1'b0, 1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic train(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, pc, taken, tgt);
    endtask

    // Monitor: compare the outputs against the oldest queued expectation.
    always @(negedge clk) begin
        if (sbQueue.size() > 0) begin
            monExp = sbQueue.pop_front();
            checkOutput(monExp);
        end
    end

    initial begin
        rst              = 1'b1;
        bus.stall        = 1'b0;
        bus.redirect     = 1'b0;
        bus.redirectPc   = 32'h0;
        bus.updateEn     = 1'b0;
        bus.updatePc     = 32'h0;
        bus.updateTaken  = 1'b0;
        bus.updateTarget = 32'h0;
        bus.imemData     = 32'h0;
        @(posedge clk);
        #1;

        $display("[TB] reset and sequential fetch");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        idle();
        idle();

        $display("[TB] stall versus redirect");
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        idle();

        $display("[TB] allocation and prediction");
        train(32'h40, 1'b1, 32'h80);
        jumpTo(32'h38);
        idle();
        idle();
        idle();
        idle();

        $display("[TB] counter saturation and hysteresis");
        train(32'h40, 1'b1, 32'h80);
        train(32'h40, 1'b1, 32'h80);
        train(32'h40, 1'b0, 32'h0);
        jumpTo(32'h40);
        idle();
        idle();
        train(32'h40, 1'b0, 32'h0);
        jumpTo(32'h40);
        idle();
        idle();

        $display("[TB] aliasing and training hazards");
        jumpTo(32'h440);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h440, 1'b0, 32'h0);
        train(32'h10, 1'b0, 32'h0);
        jumpTo(32'h10);
        idle();
        jumpTo(32'h40);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 32'h80);
        jumpTo(32'h40);
        idle();
        idle();

        $display("[TB] wrap-around");
        jumpTo(32'hFFFF_FFFC);
        idle();
        idle();

        $display("[TB] reset during training");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 32'h80);
        jumpTo(32'h40);
        idle();
        idle();

        $display("[TB] random traffic");
        for (int n = 0; n < 600; n++) begin
            bit          r;
            bit          st;
            bit          rd;
            bit          ue;
            bit          ut;
            logic [31:0] rpc;
            logic [31:0] upc;
            logic [31:0] utg;
            r   = ($urandom_range(0, 99) == 0);
            st  = ($urandom_range(0, 99) < 20);
            rd  = ($urandom_range(0, 99) < 10);
            ue  = ($urandom_range(0, 99) < 35);
            ut  = ($urandom_range(0, 2) != 0);
            rpc = randPc();
            upc = randPc();
            utg = randPc();
            applyStimulus(r, st, rd, rpc, ue, upc, ut, utg);
        end

        @(negedge clk);
        checks++;
        if (sbQueue.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", sbQueue.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
